// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: request/response and memory-strobe bundle for mem_bus_ctrl.
//   Request side : REQ_READ, REQ_WRITE, REQ_ADDR, REQ_WDATA  (control unit -> ctrl)
//   Status side  : RDATA, BUSY, DONE, ERR                    (ctrl -> control unit)
//   Memory side  : MEM_ADDR, MEM_READ, MEM_WRITE (ctrl -> mem), MEM_READY (mem -> ctrl)
// The shared tri-state MEM_DATA bus is a plain inout port of the controller,
// so that resolution happens on a single top-level net.
// Modports: slave = controller view, master = control unit + memory view.
interface mem_bus_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 26
);
  logic              REQ_READ;
  logic              REQ_WRITE;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [DATA_W-1:0] REQ_WDATA;
  logic [DATA_W-1:0] RDATA;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic              MEM_READY;

  modport slave (
    input  REQ_READ, REQ_WRITE, REQ_ADDR, REQ_WDATA, MEM_READY,
    output RDATA, BUSY, DONE, ERR, MEM_ADDR, MEM_READ, MEM_WRITE
  );

  modport master (
    output REQ_READ, REQ_WRITE, REQ_ADDR, REQ_WDATA, MEM_READY,
    input  RDATA, BUSY, DONE, ERR, MEM_ADDR, MEM_READ, MEM_WRITE
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: turns level-held READ/WRITE requests into exactly one bounded,
// handshaked access on the shared memory bus, latches read data and returns a
// one-cycle DONE (or ERR) to the control unit.
// Ports:
//   CLK       - clock, rising edge
//   RST       - asynchronous, active-low reset
//   bus       - mem_bus_ctrl_if.slave (request, status and memory strobes)
//   MEM_DATA  - shared bidirectional data bus; driven only during a write access
// Optional build macro: MEM_TIMEOUT_EN - abort an access with ERR after TIMEOUT
// cycles without MEM_READY. Without it an access waits for MEM_READY forever.
// All outputs are registered (Moore); nothing combinational from REQ_* to MEM_*.
module mem_bus_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 26,
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  mem_bus_ctrl_if.slave     bus,
  inout  wire  [DATA_W-1:0] MEM_DATA
);

  // Counter must reach both the completion point and the abort point.
  localparam int CNT_MAX = (WAIT_CYCLES > TIMEOUT) ? WAIT_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
`ifdef MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_ABORT = CNT_W'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_HOLD} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rd_q;     // MEM_READ strobe, also the latched direction
  logic              wr_q;     // MEM_WRITE strobe
  logic              oe_q;     // bus drive enable, tracks wr_q
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              req_any;

  assign req_any = bus.REQ_READ | bus.REQ_WRITE;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // DONE and ERR are single-cycle pulses.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.REQ_READ && bus.REQ_WRITE) begin
            // Conflicting request: flag it, touch nothing on the bus.
            err_q   <= 1'b1;
            state_q <= S_HOLD;
          end else if (req_any) begin
            addr_q  <= bus.REQ_ADDR;
            wdata_q <= bus.REQ_WDATA;
            cnt_q   <= '0;
            rd_q    <= bus.REQ_READ;
            wr_q    <= bus.REQ_WRITE;
            oe_q    <= bus.REQ_WRITE;
            busy_q  <= 1'b1;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
          if (cnt_q >= CNT_LAST && bus.MEM_READY) begin
            if (rd_q) rdata_q <= MEM_DATA;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            oe_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q >= CNT_ABORT) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= req_any ? S_HOLD : S_IDLE;
          end
`endif
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          // A still-held request must drop before another access can start.
          state_q <= req_any ? S_HOLD : S_IDLE;
        end
        S_HOLD: begin
          if (!req_any) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.RDATA     = rdata_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;
  assign bus.MEM_ADDR  = addr_q;
  assign bus.MEM_READ  = rd_q;
  assign bus.MEM_WRITE = wr_q;
  assign MEM_DATA      = oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: transaction-level bench for mem_bus_ctrl. Each transaction
// is described by a record (request, memory behaviour, expected outcome);
// a directed table is followed by random records whose expectations come from
// a small transaction model, plus hand sequences for reset and timeout.
// The memory side drives MEM_DATA with read data while MEM_READ is high and
// with all-zero whenever the controller is not writing, so any stray drive by
// the controller shows up as a corrupted bus value.
module tb_mem_bus_ctrl;
  localparam int DW   = 32;
  localparam int AW   = 26;
  localparam int WAIT = 2;
  localparam int TMO  = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mem_bus_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic [DW-1:0] mem_rdval = '0;
  wire  [DW-1:0] mem_data;
  wire           tb_oe  = !bus.MEM_WRITE;
  wire  [DW-1:0] tb_val = bus.MEM_READ ? mem_rdval : '0;
  assign mem_data = tb_oe ? tb_val : {DW{1'bz}};

  mem_bus_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WAIT), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .MEM_DATA(mem_data)
  );

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdval;
    int            extra;       // cycles MEM_READY stays low past the minimum
    int            req_cycles;  // cycles the request level is held
    int            exp_strobe;
    logic          exp_done;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] model_rdata = '0;
  vec_t          tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation from the request and memory behaviour.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int need;
    if (v.rd && v.wr) begin
      r.exp_strobe = 0; r.exp_done = 1'b0; r.exp_err = 1'b1; r.exp_rdata = model_rdata;
    end else begin
      need = WAIT + v.extra;
      r.exp_strobe = need; r.exp_done = 1'b1; r.exp_err = 1'b0;
      r.exp_rdata  = v.rd ? v.rdval : model_rdata;
`ifdef MEM_TIMEOUT_EN
      if (need > TMO) begin
        r.exp_strobe = TMO; r.exp_done = 1'b0; r.exp_err = 1'b1; r.exp_rdata = model_rdata;
      end
`endif
    end
    return r;
  endfunction

  // Called at a falling edge; leaves the bench at a falling edge.
  task automatic run_txn(input string tag, input vec_t v);
    int strobes = 0, dones = 0, errs = 0;
    int first_s = -1, last_s = -1, done_c = -1, err_c = -1;
    int bad_addr = 0, bad_bus = 0, bad_busy = 0, bad_dir = 0;
    int n;
    logic [DW-1:0] rd_at_done = '0;
    logic [DW-1:0] exp_bus;
    n = ((v.req_cycles > WAIT + v.extra + 2) ? v.req_cycles : WAIT + v.extra + 2) + 3;
    bus.REQ_READ  = v.rd;
    bus.REQ_WRITE = v.wr;
    bus.REQ_ADDR  = v.addr;
    bus.REQ_WDATA = v.wdata;
    mem_rdval     = v.rdval;
    bus.MEM_READY = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge CLK);
      if (bus.MEM_READ || bus.MEM_WRITE) begin
        strobes++;
        if (first_s < 0) first_s = c;
        last_s = c;
        if (bus.MEM_ADDR !== v.addr) bad_addr++;
        if (bus.MEM_READ !== v.rd || bus.MEM_WRITE !== v.wr) bad_dir++;
      end
      exp_bus = bus.MEM_WRITE ? v.wdata : (bus.MEM_READ ? v.rdval : '0);
      if (mem_data !== exp_bus) bad_bus++;
      if (bus.BUSY !== (bus.MEM_READ || bus.MEM_WRITE || bus.DONE)) bad_busy++;
      if (bus.DONE) begin dones++; if (done_c < 0) done_c = c; rd_at_done = bus.RDATA; end
      if (bus.ERR)  begin errs++;  if (err_c < 0) err_c = c; end
      if (c == v.req_cycles) begin bus.REQ_READ = 1'b0; bus.REQ_WRITE = 1'b0; end
      // Request-side address/data churn after sampling must be ignored.
      bus.REQ_ADDR  = AW'($urandom);
      bus.REQ_WDATA = $urandom;
      bus.MEM_READY = (strobes > WAIT - 1 + v.extra);
    end
    bus.MEM_READY = 1'b0;
    chk({tag, " strobe_cycles"}, 64'(strobes), 64'(v.exp_strobe));
    chk({tag, " done_pulses"},   64'(dones),   64'(v.exp_done));
    chk({tag, " err_pulses"},    64'(errs),    64'(v.exp_err));
    chk({tag, " rdata"},         64'(bus.RDATA), 64'(v.exp_rdata));
    if (v.exp_strobe > 0) chk({tag, " strobe_start"}, 64'(first_s), 64'd1);
    if (v.exp_done) begin
      chk({tag, " done_cycle"},    64'(done_c),     64'(last_s + 1));
      chk({tag, " rdata_at_done"}, 64'(rd_at_done), 64'(v.exp_rdata));
    end
    if (v.exp_err) chk({tag, " err_cycle"}, 64'(err_c), (v.rd && v.wr) ? 64'd1 : 64'(TMO + 1));
    chk({tag, " addr_errors"}, 64'(bad_addr), 64'd0);
    chk({tag, " bus_errors"},  64'(bad_bus),  64'd0);
    chk({tag, " busy_errors"}, 64'(bad_busy), 64'd0);
    chk({tag, " dir_errors"},  64'(bad_dir),  64'd0);
    model_rdata = v.exp_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bad_rst;
    vec_t v;
    int strobes, dones, errs, err_c;
    logic busy100;

    //          rd    wr    addr          wdata         rdval         ex req stb done  err   rdata
    tbl[0] = '{1'b1, 1'b0, 26'h0000010,  32'h55AA55AA, 32'h20020005, 0, 1, 2, 1'b1, 1'b0, 32'h20020005};
    tbl[1] = '{1'b0, 1'b1, 26'h3FFFFFF,  32'hDEADBEEF, 32'h00000000, 3, 10, 5, 1'b1, 1'b0, 32'h20020005};
    tbl[2] = '{1'b1, 1'b1, 26'h0000ABC,  32'h11111111, 32'h22222222, 0, 3, 0, 1'b0, 1'b1, 32'h20020005};
    tbl[3] = '{1'b1, 1'b0, 26'h1234567,  32'hFFFFFFFF, 32'hA5A50F0F, 1, 6, 3, 1'b1, 1'b0, 32'hA5A50F0F};
    tbl[4] = '{1'b0, 1'b1, 26'h0000000,  32'hFFFFFFFF, 32'h00000000, 0, 2, 2, 1'b1, 1'b0, 32'hA5A50F0F};
    tbl[5] = '{1'b1, 1'b0, 26'h2AAAAAA,  32'h0F0F0F0F, 32'h00000000, 5, 1, 7, 1'b1, 1'b0, 32'h00000000};

    // Reset held with random activity on every input.
    bad_rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      bus.REQ_READ  = 1'($urandom);
      bus.REQ_WRITE = 1'($urandom);
      bus.REQ_ADDR  = AW'($urandom);
      bus.REQ_WDATA = $urandom;
      bus.MEM_READY = 1'($urandom);
      mem_rdval     = $urandom;
      #1;
      if (bus.RDATA !== '0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.ERR !== 1'b0 ||
          bus.MEM_ADDR !== '0 || bus.MEM_READ !== 1'b0 || bus.MEM_WRITE !== 1'b0 ||
          mem_data !== '0) bad_rst++;
    end
    chk("reset outputs_nonzero", 64'(bad_rst), 64'd0);
    chk("reset rdata", 64'(bus.RDATA), 64'd0);
    bus.REQ_READ = 1'b0; bus.REQ_WRITE = 1'b0; bus.MEM_READY = 1'b0;
    @(negedge CLK) RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post_reset busy", 64'(bus.BUSY), 64'd0);
    chk("post_reset strobes", 64'({bus.MEM_READ, bus.MEM_WRITE}), 64'd0);

    // Directed table.
    for (int i = 0; i < 6; i++) run_txn($sformatf("tbl%0d", i), tbl[i]);

    // Reset in the second cycle of a write.
    bus.REQ_WRITE = 1'b1; bus.REQ_READ = 1'b0;
    bus.REQ_ADDR  = 26'h0000155; bus.REQ_WDATA = 32'h12345678; bus.MEM_READY = 1'b0;
    repeat (2) @(negedge CLK);
    chk("midwr strobe", 64'(bus.MEM_WRITE), 64'd1);
    chk("midwr bus", 64'(mem_data), 64'h12345678);
    #2 RST = 1'b0;
    #1;
    chk("midwr_rst strobe", 64'(bus.MEM_WRITE), 64'd0);
    chk("midwr_rst bus", 64'(mem_data), 64'd0);
    chk("midwr_rst busy", 64'(bus.BUSY), 64'd0);
    chk("midwr_rst rdata", 64'(bus.RDATA), 64'd0);
    model_rdata = '0;
    bus.REQ_WRITE = 1'b0;
    @(negedge CLK) RST = 1'b1;
    @(negedge CLK);
    v = '{1'b1, 1'b0, 26'h0000200, 32'h0, 32'h600DF00D, 1, 1, 0, 1'b0, 1'b0, '0};
    run_txn("after_rst", model(v));

    // Random transactions against the model.
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 7);
      v.rd = (k <= 3); v.wr = (k == 0) || (k >= 4);
      v.addr = AW'($urandom); v.wdata = $urandom; v.rdval = $urandom;
      v.extra = $urandom_range(0, 6); v.req_cycles = $urandom_range(1, 10);
      run_txn($sformatf("rnd%0d", i), model(v));
    end

    // MEM_READY stuck low.
    strobes = 0; dones = 0; errs = 0; err_c = -1; busy100 = 1'b0;
    bus.REQ_READ = 1'b1; bus.REQ_WRITE = 1'b0;
    bus.REQ_ADDR = 26'h0000777; mem_rdval = 32'hCAFEF00D; bus.MEM_READY = 1'b0;
    for (int c = 1; c <= 110; c++) begin
      @(negedge CLK);
      if (bus.MEM_READ) strobes++;
      if (bus.DONE) dones++;
      if (bus.ERR) begin errs++; if (err_c < 0) err_c = c; end
      if (c == 100) busy100 = bus.BUSY;
      if (c == 1) bus.REQ_READ = 1'b0;
    end
`ifdef MEM_TIMEOUT_EN
    chk("tmo strobe_cycles", 64'(strobes), 64'(TMO));
    chk("tmo err_pulses", 64'(errs), 64'd1);
    chk("tmo err_cycle", 64'(err_c), 64'(TMO + 1));
    chk("tmo done_pulses", 64'(dones), 64'd0);
    chk("tmo rdata", 64'(bus.RDATA), 64'(model_rdata));
    chk("tmo busy_end", 64'(bus.BUSY), 64'd0);
`else
    chk("stuck busy_at_100", 64'(busy100), 64'd1);
    chk("stuck strobe_cycles", 64'(strobes), 64'd110);
    chk("stuck err_pulses", 64'(errs), 64'd0);
    chk("stuck done_pulses", 64'(dones), 64'd0);
    bus.MEM_READY = 1'b1;
    @(negedge CLK);
    chk("stuck release done", 64'(bus.DONE), 64'd1);
    chk("stuck release rdata", 64'(bus.RDATA), 64'hCAFEF00D);
    model_rdata = 32'hCAFEF00D;
    bus.MEM_READY = 1'b0;
    @(negedge CLK);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
